muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req  input  1  pipeline requests an M-extension op; held with op/a/b stable until ack.
REQ-005 op  input  3  mul_ops (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
REQ-006 a, b  input  32 each  rs1/rs2 operands.
REQ-007 stall  input  1  pipeline freeze; holds controller state.
REQ-008 ack  output  1  result valid; held while stall is high.
REQ-009 result  output  32  selected muldiv result, valid when ack=1.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 unit_run, unit_div, unit_stall  output  1 each  iterative unit start-and-hold, divide select, stall pass-through.
REQ-012 unit_opA, unit_opB  output  33 each  sign- or zero-extended operands.
REQ-013 unit_resp  input  1  iterative unit done.
REQ-014 unit_Aval, unit_Bval  input  33 each  iterative unit high and low result registers.

Function
REQ-015 SHALL implement an FSM with states IDLE, FAST, RUN, DONE.
REQ-016 IDLE with req=1 and stall=0 SHALL latch op, a and b, then go to FAST when a special case or cache hit applies, otherwise to RUN.
REQ-017 Special cases SHALL bypass the unit:
- div/divu with b=0: quotient 0xFFFFFFFF.
- rem/remu with b=0: result a.
- div with a=0x80000000 and b=0xFFFFFFFF: quotient 0x80000000.
- rem with the same operands: result 0.
REQ-018 Cache SHALL hold {valid, a, b, signedness class, kind (mul or div), lo, hi}. A hit is a match on all fields with valid=1; hi/lo SHALL supply mulh*/mul and rem/div results.
REQ-019 RUN SHALL hold unit_run=1 until unit_resp is sampled high, then go to DONE.
REQ-020 Operand extension: signed inputs sign-extend to 33 bits, unsigned inputs zero-extend. mulhsu SHALL sign-extend a and zero-extend b. unit_div=1 for div/divu/rem/remu.
REQ-021 Result selection from the unit:
- mul, div, divu: Bval[31:0].
- mulh, mulhsu, mulhu: {Aval[30:0], Bval[32]}.
- rem, remu: Aval[31:0].
REQ-022 On unit_resp, the controller SHALL write both halves into the cache and set valid.
REQ-023 FAST and DONE SHALL assert ack with a registered result.
- ack=1 and stall=0: return to IDLE next cycle.
- ack=1 and stall=1: hold ack and result.
REQ-024 Latency: fast path ack one cycle after acceptance; iterative path ack one cycle after unit_resp is sampled.
REQ-025 stall=1 SHALL freeze FSM state and the cache; unit_stall SHALL equal stall.
REQ-026 unit_run SHALL be 0 in IDLE, FAST and DONE.
REQ-027 A new req SHALL NOT be accepted in the cycle ack is high; a back-to-back op is accepted the next IDLE cycle.
REQ-028 Dropping req before ack is illegal; the bench SHALL flag it with an assertion.

Reset
REQ-029 rst=1 SHALL force state to IDLE and set ack=0, busy=0, unit_run=0, result=0 and cache valid=0, on the next clock edge.
REQ-030 rst during RUN SHALL abort the operation with no ack and no cache update.

Structure
REQ-031 mul_ops SHALL reside in the shared rv32i_types package with funct3 encoding 0..7; the FSM state enum SHALL be local.
REQ-032 Sub-module muldiv_special SHALL be combinational, flag the special cases and supply their result.
REQ-033 The Multiplier instance SHALL remain outside this block.

Verification
REQ-034 divu a=100, b=0 -> ack one cycle after acceptance, result 0xFFFFFFFF, unit_run never high.
REQ-035 div a=0x80000000, b=0xFFFFFFFF -> fast ack, result 0x80000000; same operands with rem -> fast ack, result 0.
REQ-036 div a=-7, b=2 (unit model) -> result 0xFFFFFFFD; back-to-back rem with same operands -> cache hit, fast ack, result 0xFFFFFFFF.
REQ-037 mulhu a=0xFFFFFFFF, b=0xFFFFFFFF -> RUN path, result 0xFFFFFFFE; then mul with the same a/b -> cache hit, result 0x00000001.
REQ-038 stall=1 for 3 cycles during DONE -> ack and result stable throughout; IDLE one cycle after stall drops.
REQ-039 rst asserted mid-RUN -> next cycle IDLE, busy=0, unit_run=0; the following rem with the same operands takes the RUN path (cache cleared).

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared RV32I M-extension types: op encoding (funct3 order), cache entry layout
// and small helpers for operand signedness and result-half selection.
package rv32i_types;

  typedef enum logic [2:0] {
    mul    = 3'd0,
    mulh   = 3'd1,
    mulhsu = 3'd2,
    mulhu  = 3'd3,
    div    = 3'd4,
    divu   = 3'd5,
    rem    = 3'd6,
    remu   = 3'd7
  } mul_ops;

  typedef enum logic [1:0] {
    CLS_SS = 2'd0,
    CLS_SU = 2'd1,
    CLS_UU = 2'd2
  } sign_cls_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    sign_cls_e   cls;
    logic        is_div;
    logic [31:0] lo;
    logic [31:0] hi;
  } muldiv_cache_t;

  function automatic logic op_is_div(input mul_ops op);
    return op inside {div, divu, rem, remu};
  endfunction

  function automatic logic a_signed(input mul_ops op);
    return op inside {mul, mulh, mulhsu, div, rem};
  endfunction

  function automatic logic b_signed(input mul_ops op);
    return op inside {mul, mulh, div, rem};
  endfunction

  function automatic sign_cls_e op_class(input mul_ops op);
    if (a_signed(op) && b_signed(op)) return CLS_SS;
    if (a_signed(op)) return CLS_SU;
    return CLS_UU;
  endfunction

  // High half: upper product word for mulh*, remainder for rem*.
  function automatic logic op_uses_hi(input mul_ops op);
    return op inside {mulh, mulhsu, mulhu, rem, remu};
  endfunction

  function automatic logic [32:0] extend33(input logic [31:0] v, input logic sgn);
    return {sgn & v[31], v};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_special.sv
// Combinational detection of divide corner cases that bypass the iterative unit,
// together with the architecturally defined result for each.
module muldiv_special
  import rv32i_types::*;
(
  input  mul_ops      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        special,
  output logic [31:0] result
);

  logic b_zero;
  logic overflow;

  assign b_zero   = (b == '0);
  assign overflow = (a == 32'h8000_0000) && (b == '1);

  always_comb begin
    special = 1'b0;
    result  = '0;
    unique case (op)
      div, divu: begin
        if (b_zero) begin
          special = 1'b1;
          result  = '1;
        end else if (op == div && overflow) begin
          special = 1'b1;
          result  = 32'h8000_0000;
        end
      end
      rem, remu: begin
        if (b_zero) begin
          special = 1'b1;
          result  = a;
        end else if (op == rem && overflow) begin
          special = 1'b1;
          result  = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// M-extension controller: accepts one op at a time, answers corner cases and
// repeat operand pairs from a one-entry cache, otherwise runs the iterative unit.
module muldiv_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        stall,
  output logic        ack,
  output logic [31:0] result,
  output logic        busy,
  output logic        unit_run,
  output logic        unit_div,
  output logic        unit_stall,
  output logic [32:0] unit_opA,
  output logic [32:0] unit_opB,
  input  logic        unit_resp,
  input  logic [32:0] unit_Aval,
  input  logic [32:0] unit_Bval
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FAST = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state, state_d;
  mul_ops        op_in, op_q;
  logic [31:0]   a_q, b_q, result_q;
  muldiv_cache_t cache;

  logic        special;
  logic [31:0] special_result;
  logic        hit;
  logic [31:0] hit_result;
  logic [31:0] unit_result;
  logic [31:0] unit_hi;
  logic        accept, finish;
  logic        unused_aval_msb;

  assign op_in = mul_ops'(op);

  muldiv_special u_special (
    .op      (op_in),
    .a       (a),
    .b       (b),
    .special (special),
    .result  (special_result)
  );

  // mul only needs the low product word, which is identical for every
  // signedness class, so it may reuse any cached multiply entry.
  assign hit = cache.valid && (cache.a == a) && (cache.b == b)
            && (cache.is_div == op_is_div(op_in))
            && ((cache.cls == op_class(op_in)) || (op_in == mul));
  assign hit_result = op_uses_hi(op_in) ? cache.hi : cache.lo;

  assign unit_hi = op_is_div(op_q) ? unit_Aval[31:0] : {unit_Aval[30:0], unit_Bval[32]};

  always_comb begin
    unit_result = unit_Bval[31:0];
    if (op_uses_hi(op_q)) unit_result = unit_hi;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !stall) begin
          accept  = 1'b1;
          state_d = (special || hit) ? FAST : RUN;
        end
      end
      RUN: begin
        if (unit_resp && !stall) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      FAST, DONE: begin
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= mul;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cache    <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q <= op_in;
        a_q  <= a;
        b_q  <= b;
        if (special) result_q <= special_result;
        else if (hit) result_q <= hit_result;
      end
      if (finish) begin
        result_q     <= unit_result;
        cache.valid  <= 1'b1;
        cache.a      <= a_q;
        cache.b      <= b_q;
        cache.cls    <= op_class(op_q);
        cache.is_div <= op_is_div(op_q);
        cache.lo     <= unit_Bval[31:0];
        cache.hi     <= unit_hi;
      end
    end
  end

  assign ack        = (state == FAST) || (state == DONE);
  assign busy       = (state != IDLE);
  assign result     = result_q;
  assign unit_run   = (state == RUN);
  assign unit_div   = op_is_div(op_q);
  assign unit_stall = stall;
  assign unit_opA   = extend33(a_q, a_signed(op_q));
  assign unit_opB   = extend33(b_q, b_signed(op_q));

  assign unused_aval_msb = unit_Aval[32];

endmodule
